sram_port_arbiter: RTL and testbench

//  Shares one req/addr_ok/data_ok SRAM-like memory port between the fetch-side (inst) and

---
 rtl/sram_port_arbiter_if.sv | 22 ++
 rtl/sram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - one req/addr_ok/data_ok SRAM-like memory port
interface sram_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between inst and data requesters
module sram_port_arbiter #(
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    sram_port_arbiter_if.slave        inst,
    sram_port_arbiter_if.slave        data,
    sram_port_arbiter_if.master       mem,
    output logic                      err_stray_ok
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(MAX_OUTST);
    localparam logic [PW-1:0] LAST_PTR   = PW'(MAX_OUTST - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                 lock_valid;
    logic                 lock_id;
    logic [MAX_OUTST-1:0] q_id;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [SW-1:0]        starve_cnt;

    logic owner;
    logic owner_req;
    logic grant;
    logic accept;
    logic pop;
    logic head_id;

    // owner: 0 = inst, 1 = data; a pending handshake keeps its owner
    always_comb begin
        if (lock_valid)
            owner = lock_id;
        else if (inst.req && data.req)
            owner = (starve_cnt != STARVE_MAX);
        else
            owner = data.req;
    end

    assign owner_req = owner ? data.req : inst.req;
    assign grant     = resetn & (count != FULL_CNT) & owner_req;
    assign accept    = grant & mem.addr_ok;
    assign pop       = resetn & mem.data_ok & (count != '0);
    assign head_id   = q_id[rd_ptr];

    assign mem.req = grant;

    always_comb begin
        mem.wr    = 1'b0;
        mem.size  = '0;
        mem.wstrb = '0;
        mem.addr  = '0;
        mem.wdata = '0;
        if (resetn) begin
            if (grant && owner) begin
                mem.wr    = data.wr;
                mem.size  = data.size;
                mem.wstrb = data.wstrb;
                mem.addr  = data.addr;
                mem.wdata = data.wdata;
            end else begin
                mem.wr    = inst.wr;
                mem.size  = inst.size;
                mem.wstrb = inst.wstrb;
                mem.addr  = inst.addr;
                mem.wdata = inst.wdata;
            end
        end
    end

    assign inst.addr_ok = accept & ~owner;
    assign data.addr_ok = accept & owner;
    assign inst.data_ok = pop & ~head_id;
    assign data.data_ok = pop & head_id;
    assign inst.rdata   = resetn ? mem.rdata : '0;
    assign data.rdata   = resetn ? mem.rdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_valid   <= 1'b0;
            lock_id      <= 1'b0;
            q_id         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            err_stray_ok <= 1'b0;
        end else begin
            if (accept) begin
                lock_valid <= 1'b0;
            end else if (grant) begin
                lock_valid <= 1'b1;
                lock_id    <= owner;
            end

            if (accept) begin
                q_id[wr_ptr] <= owner;
                wr_ptr       <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;

            if (mem.data_ok && count == '0)
                err_stray_ok <= 1'b1;

            if (!inst.req || (accept && !owner))
                starve_cnt <= '0;
            else if (accept && owner && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic resetn;
    logic err;
    int   total  = 0;
    int   passed = 0;
    bit   sb[$];

    sram_port_arbiter_if inst_if();
    sram_port_arbiter_if data_if();
    sram_port_arbiter_if mem_if();

    sram_port_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst         (inst_if),
        .data         (data_if),
        .mem          (mem_if),
        .err_stray_ok (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.wstrb = 4'hF;
        inst_if.addr = '0; inst_if.wdata = '0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.wstrb = 4'hF;
        data_if.addr = '0; data_if.wdata = '0;
        mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = '0;
    endtask

    // expected grant owner/address; pushes the owner when the handshake completes
    task automatic grant(input string tag, input bit id, input logic [31:0] addr);
        chk({tag, "_req"}, mem_if.req, 1);
        chk({tag, "_addr"}, mem_if.addr, addr);
        chk({tag, "_iaok"}, inst_if.addr_ok, mem_if.addr_ok & ~id);
        chk({tag, "_daok"}, data_if.addr_ok, mem_if.addr_ok & id);
        if (mem_if.addr_ok) sb.push_back(id);
    endtask

    task automatic resp(input string tag, input logic [31:0] rdata);
        bit id;
        chk({tag, "_sb"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            id = sb.pop_front();
            chk({tag, "_idok"}, inst_if.data_ok, !id);
            chk({tag, "_ddok"}, data_if.data_ok, id);
            chk({tag, "_rdata"}, id ? data_if.rdata : inst_if.rdata, rdata);
        end
    endtask

    task automatic no_resp(input string tag);
        chk({tag, "_idok"}, inst_if.data_ok, 0);
        chk({tag, "_ddok"}, data_if.data_ok, 0);
    endtask

    initial begin
        idle();
        resetn = 0;
        inst_if.req = 1; inst_if.addr = 32'h1234_5678;
        data_if.req = 1;
        mem_if.addr_ok = 1; mem_if.data_ok = 1; mem_if.rdata = 32'hDEAD_BEEF;
        #3;
        chk("rst_mreq", mem_if.req, 0);
        chk("rst_maddr", mem_if.addr, 0);
        chk("rst_iaok", inst_if.addr_ok, 0);
        chk("rst_daok", data_if.addr_ok, 0);
        no_resp("rst");
        chk("rst_irdata", inst_if.rdata, 0);
        chk("rst_err", err, 0);
        #9;
        resetn = 1;
        idle();
        adv();

        // T1: inst only
        inst_if.req = 1; inst_if.addr = 32'h1C00_0000; mem_if.addr_ok = 1;
        #1;
        grant("t1_grant", 0, 32'h1C00_0000);
        chk("t1_ddok0", data_if.data_ok, 0);
        adv();
        inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'hCAFE_0001;
        #1;
        resp("t1_resp", 32'hCAFE_0001);
        chk("t1_daok", data_if.addr_ok, 0);
        adv();
        idle();

        // T2: both request, data first
        inst_if.req = 1; inst_if.addr = 32'h100;
        data_if.req = 1; data_if.addr = 32'h200; mem_if.addr_ok = 1;
        #1;
        grant("t2_g0", 1, 32'h200);
        adv();
        data_if.req = 0;
        #1;
        grant("t2_g1", 0, 32'h100);
        adv();
        inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'hA0A0_0002;
        #1;
        resp("t2_r0", 32'hA0A0_0002);
        adv();
        mem_if.rdata = 32'hB0B0_0003;
        #1;
        resp("t2_r1", 32'hB0B0_0003);
        adv();
        idle();

        // T3: grant locked to data while address phase stalls
        data_if.req = 1; data_if.addr = 32'h8;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) begin inst_if.req = 1; inst_if.addr = 32'h300; end
            #1;
            grant($sformatf("t3_stall%0d", c), 1, 32'h8);
            adv();
        end
        mem_if.addr_ok = 1;
        #1;
        grant("t3_acc", 1, 32'h8);
        adv();
        data_if.req = 0;
        #1;
        grant("t3_inst", 0, 32'h300);
        adv();
        inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h3333_0001;
        #1;
        resp("t3_r0", 32'h3333_0001);
        adv();
        mem_if.rdata = 32'h3333_0002;
        #1;
        resp("t3_r1", 32'h3333_0002);
        adv();
        idle();

        // T4: starvation forcing one inst grant after 3 data grants
        data_if.req = 1; data_if.addr = 32'h400;
        inst_if.req = 1; inst_if.addr = 32'h500; mem_if.addr_ok = 1;
        for (int i = 0; i < 5; i++) begin
            mem_if.data_ok = (i > 0);
            mem_if.rdata = 32'h4000 + i;
            #1;
            if (i > 0) resp($sformatf("t4_resp%0d", i), 32'h4000 + i);
            grant($sformatf("t4_grant%0d", i), (i == 3) ? 1'b0 : 1'b1, (i == 3) ? 32'h500 : 32'h400);
            adv();
        end
        inst_if.req = 0; data_if.req = 0; mem_if.addr_ok = 0;
        mem_if.data_ok = 1; mem_if.rdata = 32'h4005;
        #1;
        resp("t4_drain", 32'h4005);
        adv();
        idle();

        // T5: queue full, pop/push same cycle, stray response
        data_if.req = 1; data_if.addr = 32'h600; mem_if.addr_ok = 1;
        #1; grant("t5_g0", 1, 32'h600); adv();
        #1; grant("t5_g1", 1, 32'h600); adv();
        #1;
        chk("t5_full_req", mem_if.req, 0);
        chk("t5_full_daok", data_if.addr_ok, 0);
        adv();
        mem_if.data_ok = 1; mem_if.rdata = 32'h5004;
        #1;
        chk("t5_full_pop_req", mem_if.req, 0);
        resp("t5_r0", 32'h5004);
        adv();
        mem_if.rdata = 32'h5005;
        #1;
        resp("t5_r1", 32'h5005);
        grant("t5_g2", 1, 32'h600);
        adv();
        mem_if.data_ok = 0;
        #1; grant("t5_g3", 1, 32'h600); adv();
        #1;
        chk("t5_full2_req", mem_if.req, 0);
        chk("t5_err0", err, 0);
        adv();
        data_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h5008;
        #1; resp("t5_r2", 32'h5008); adv();
        mem_if.rdata = 32'h5009;
        #1; resp("t5_r3", 32'h5009); adv();
        #1; no_resp("t5_stray"); adv();
        mem_if.data_ok = 0;
        #1;
        chk("t5_err1", err, 1);
        adv();
        idle();

        // T6: reset mid-lock with one outstanding
        inst_if.req = 1; inst_if.addr = 32'h700; mem_if.addr_ok = 1;
        #1; grant("t6_g0", 0, 32'h700); adv();
        inst_if.req = 0; data_if.req = 1; data_if.addr = 32'h800; mem_if.addr_ok = 0;
        #1; grant("t6_lock", 1, 32'h800); adv();
        resetn = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h6666;
        #1;
        chk("t6_rst_mreq", mem_if.req, 0);
        chk("t6_rst_maddr", mem_if.addr, 0);
        no_resp("t6_rst");
        chk("t6_rst_drdata", data_if.rdata, 0);
        chk("t6_rst_err", err, 0);
        sb.delete();
        adv();
        resetn = 1;
        idle();
        inst_if.req = 1; inst_if.addr = 32'h900;
        #1;
        grant("t6_nolock", 0, 32'h900);
        adv();
        inst_if.req = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h7777;
        #1;
        no_resp("t6_empty");
        chk("t6_err0", err, 0);
        adv();
        mem_if.data_ok = 0;
        #1;
        chk("t6_err1", err, 1);
        adv();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
